// File: rtl/rv_pkg.sv
// Shared definitions for the hart scheduler: parameter defaults,
// counter width and the hart-ID width helper.
package rv_pkg;

    localparam int DEF_NUM_HARTS  = 8;
    localparam int DEF_PIPE_DEPTH = 6;
    localparam int BUBBLE_W       = 32;

    // Hart-ID width: clog2 of the hart count, never narrower than one bit.
    function automatic int hart_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rv_hart_sched_if.sv
// Bundle of the scheduler's control inputs and pipeline-occupancy outputs.
// issue_valid has no ready partner: a slot is issued whenever issue_valid
// is high, and the consumer must accept it in that cycle. There is no
// back-pressure anywhere in the occupancy pipeline.
interface rv_hart_sched_if
    import rv_pkg::*;
#(
    parameter int NUM_HARTS  = DEF_NUM_HARTS,
    parameter int PIPE_DEPTH = DEF_PIPE_DEPTH
) ();
    localparam int HART_W = hart_w(NUM_HARTS);

    logic [NUM_HARTS-1:0]         run_mask;
    logic                         sleep_req;
    logic [NUM_HARTS-1:0]         wake;
    logic                         issue_valid;
    logic [HART_W-1:0]            issue_hart;
    logic [PIPE_DEPTH-1:0]        stage_valid;
    logic [PIPE_DEPTH*HART_W-1:0] stage_hart;
    logic                         retire_valid;
    logic [HART_W-1:0]            retire_hart;
    logic [BUBBLE_W-1:0]          bubble_cnt;

    // Scheduler side.
    modport master (
        input  run_mask, sleep_req, wake,
        output issue_valid, issue_hart, stage_valid, stage_hart,
               retire_valid, retire_hart, bubble_cnt
    );

    // Environment / pipeline side.
    modport slave (
        output run_mask, sleep_req, wake,
        input  issue_valid, issue_hart, stage_valid, stage_hart,
               retire_valid, retire_hart, bubble_cnt
    );
endinterface

// File: rtl/rv_rr_arbiter.sv
// Rotating-priority picker: starting one past the pointer, grants the
// first requesting index. Purely combinational.
module rv_rr_arbiter #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx
);
    // Scan N positions beginning after ptr; the first hit wins.
    always_comb begin
        int idx;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = W'(idx);
            end
        end
    end
endmodule

// File: rtl/rv_hart_sched.sv
// Barrel-style hart scheduler: at most one instruction per hart in flight,
// round-robin pick among eligible harts, occupancy tracked per pipe stage.
module rv_hart_sched
    import rv_pkg::*;
#(
    parameter int NUM_HARTS  = DEF_NUM_HARTS,
    parameter int PIPE_DEPTH = DEF_PIPE_DEPTH
) (
    input logic            clk,
    input logic            rst_n,
    rv_hart_sched_if.master bus
);
    localparam int HART_W = hart_w(NUM_HARTS);

    logic [PIPE_DEPTH-1:0]             v_q;
    logic [PIPE_DEPTH-1:0][HART_W-1:0] h_q;
    logic [NUM_HARTS-1:0]              in_flight_q;
    logic [NUM_HARTS-1:0]              sleep_q;
    logic [HART_W-1:0]                 last_q;
    logic [BUBBLE_W-1:0]               bubble_q;

    logic                 retire_v;
    logic [HART_W-1:0]    retire_h;
    logic [NUM_HARTS-1:0] ret_dec;
    logic [NUM_HARTS-1:0] iss_dec;
    logic [NUM_HARTS-1:0] req;
    logic [NUM_HARTS-1:0] in_flight_d;
    logic [NUM_HARTS-1:0] sleep_d;
    logic                 gnt_v;
    logic [HART_W-1:0]    gnt_idx;

    assign retire_v = v_q[PIPE_DEPTH-1];
    assign retire_h = h_q[PIPE_DEPTH-1];

    // Decode retire/issue, form eligibility (retiring hart is already free)
    // and compute next in-flight / sleep vectors.
    always_comb begin
        ret_dec = '0;
        iss_dec = '0;
        if (retire_v) ret_dec[retire_h] = 1'b1;
        if (gnt_v)    iss_dec[gnt_idx]  = 1'b1;
        req         = bus.run_mask & ~sleep_q & ~(in_flight_q & ~ret_dec);
        in_flight_d = (in_flight_q & ~ret_dec) | iss_dec;
        // Wake overrides a same-cycle sleep request.
        sleep_d     = (sleep_q | (bus.sleep_req ? ret_dec : '0)) & ~bus.wake;
    end

    rv_rr_arbiter #(
        .N (NUM_HARTS),
        .W (HART_W)
    ) u_arb (
        .req       (req),
        .ptr       (last_q),
        .gnt_valid (gnt_v),
        .gnt_idx   (gnt_idx)
    );

    // Advance the occupancy pipeline and scheduler state each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q         <= '0;
            h_q         <= '0;
            in_flight_q <= '0;
            sleep_q     <= '0;
            last_q      <= HART_W'(NUM_HARTS - 1);
            bubble_q    <= '0;
        end else begin
            v_q         <= {v_q[PIPE_DEPTH-2:0], gnt_v};
            h_q         <= {h_q[PIPE_DEPTH-2:0], (gnt_v ? gnt_idx : HART_W'(0))};
            in_flight_q <= in_flight_d;
            sleep_q     <= sleep_d;
            if (gnt_v) begin
                last_q <= gnt_idx;
            end else if (bubble_q != {BUBBLE_W{1'b1}}) begin
                bubble_q <= bubble_q + BUBBLE_W'(1);
            end
        end
    end

    assign bus.issue_valid  = v_q[0];
    assign bus.issue_hart   = h_q[0];
    assign bus.stage_valid  = v_q;
    assign bus.stage_hart   = h_q;
    assign bus.retire_valid = retire_v;
    assign bus.retire_hart  = retire_h;
    assign bus.bubble_cnt   = bubble_q;
endmodule

// File: tb/tb_rv_hart_sched.sv
// Self-checking bench for rv_hart_sched: an 8-hart instance checked against
// a pipeline-array reference model, plus a 4-hart instance for the
// bubble pattern when harts are fewer than stages.
module tb_rv_hart_sched;
    localparam int N8 = 8;
    localparam int D  = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: hart ID per stage (-1 = empty), sleep flags,
    // last issued hart and bubble count.
    int m_pipe [D];
    bit m_sleep [N8];
    int m_last;
    int m_bub;

    logic [3:0] exp_q [$];

    always #5 clk = ~clk;

    rv_hart_sched_if #(.NUM_HARTS(8), .PIPE_DEPTH(6)) bus8 ();
    rv_hart_sched_if #(.NUM_HARTS(4), .PIPE_DEPTH(6)) bus4 ();

    rv_hart_sched #(.NUM_HARTS(8), .PIPE_DEPTH(6)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    rv_hart_sched #(.NUM_HARTS(4), .PIPE_DEPTH(6)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    task automatic m_reset();
        for (int k = 0; k < D; k++) m_pipe[k] = -1;
        for (int i = 0; i < N8; i++) m_sleep[i] = 1'b0;
        m_last = N8 - 1;
        m_bub  = 0;
    endtask

    // One clock of the model: a hart is free if it is not in stages 0..D-2
    // (the one in the last stage retires this cycle).
    task automatic m_step(input logic [7:0] mask, input logic sreq, input logic [7:0] wk);
        int pick;
        int h;
        bit busy;
        pick = -1;
        for (int i = 1; i <= N8 && pick < 0; i++) begin
            h = (m_last + i) % N8;
            busy = 1'b0;
            for (int k = 0; k < D - 1; k++) if (m_pipe[k] == h) busy = 1'b1;
            if (mask[h] && !m_sleep[h] && !busy) pick = h;
        end
        if (m_pipe[D-1] >= 0 && sreq) m_sleep[m_pipe[D-1]] = 1'b1;
        for (int i = 0; i < N8; i++) if (wk[i]) m_sleep[i] = 1'b0;
        for (int k = D - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
        m_pipe[0] = pick;
        if (pick >= 0) m_last = pick;
        else m_bub++;
    endtask

    // Apply inputs for one clock (called at a falling edge), step the model.
    task automatic drive(input logic [7:0] mask, input logic sreq, input logic [7:0] wk);
        bus8.run_mask  = mask;
        bus8.sleep_req = sreq;
        bus8.wake      = wk;
        m_step(mask, sreq, wk);
        @(posedge clk);
        @(negedge clk);
        bus8.sleep_req = 1'b0;
        bus8.wake      = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (bus8.issue_valid !== 1'b0 || bus8.issue_hart !== 3'd0 || bus8.stage_valid !== 6'd0 ||
            bus8.stage_hart !== 18'd0 || bus8.retire_valid !== 1'b0 || bus8.retire_hart !== 3'd0) begin
            n_fail++;
            $display("FAIL reset8: iv=%0b ih=%0d sv=%b sh=%h rv=%0b rh=%0d want all 0",
                     bus8.issue_valid, bus8.issue_hart, bus8.stage_valid, bus8.stage_hart,
                     bus8.retire_valid, bus8.retire_hart);
        end
        n_checks++;
        if (bus8.bubble_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset8_bubble: got %0d want 0", bus8.bubble_cnt);
        end
        n_checks++;
        if (bus4.stage_valid !== 6'd0 || bus4.stage_hart !== 12'd0 || bus4.bubble_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset4: sv=%b sh=%h bub=%0d want 0", bus4.stage_valid, bus4.stage_hart, bus4.bubble_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
    endtask

    task automatic test_rr_n8();
        do_reset();
        for (int c = 0; c < 40; c++) begin
            n_checks++;
            if (c == 0 ? (bus8.issue_valid !== 1'b0)
                       : (bus8.issue_valid !== 1'b1 || bus8.issue_hart !== 3'((c - 1) % N8))) begin
                n_fail++;
                $display("FAIL rr_seq c=%0d: got v=%0b h=%0d want h=%0d", c, bus8.issue_valid,
                         bus8.issue_hart, (c - 1) % N8);
            end
            for (int k = 0; k < D; k++) begin
                n_checks++;
                if (bus8.stage_valid[k] !== (m_pipe[k] >= 0) ||
                    (m_pipe[k] >= 0 && bus8.stage_hart[k*3 +: 3] !== 3'(m_pipe[k]))) begin
                    n_fail++;
                    $display("FAIL rr_stage%0d c=%0d: got v=%0b h=%0d want %0d", k, c,
                             bus8.stage_valid[k], bus8.stage_hart[k*3 +: 3], m_pipe[k]);
                end
            end
            drive(8'hFF, 1'b0, 8'h00);
        end
        n_checks++;
        if (bus8.bubble_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL rr_bubble: got %0d want 0", bus8.bubble_cnt);
        end
    endtask

    task automatic test_n4_bubbles();
        bus4.run_mask = 4'hF;
        do_reset();
        exp_q = {4'd0, 4'd1, 4'd2, 4'd3, 4'hF, 4'hF, 4'd0, 4'd1, 4'd2, 4'd3, 4'hF, 4'hF};
        for (int c = 1; c <= 12; c++) begin
            logic [3:0] e;
            @(posedge clk);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ((e == 4'hF) ? (bus4.issue_valid !== 1'b0)
                            : (bus4.issue_valid !== 1'b1 || bus4.issue_hart !== e[1:0])) begin
                n_fail++;
                $display("FAIL n4_seq c=%0d: got v=%0b h=%0d want %0h (F=bubble)", c,
                         bus4.issue_valid, bus4.issue_hart, e);
            end
        end
        n_checks++;
        if (bus4.bubble_cnt !== 32'd4) begin
            n_fail++;
            $display("FAIL n4_bubble: got %0d want 4", bus4.bubble_cnt);
        end
        m_reset();
        do_reset();
    endtask

    task automatic test_mask_0101();
        do_reset();
        for (int c = 0; c < 30; c++) begin
            drive(8'h05, 1'b0, 8'h00);
            n_checks++;
            if (bus8.issue_valid !== (m_pipe[0] >= 0) ||
                (m_pipe[0] >= 0 && bus8.issue_hart !== 3'(m_pipe[0]))) begin
                n_fail++;
                $display("FAIL mask_issue c=%0d: got v=%0b h=%0d want %0d", c,
                         bus8.issue_valid, bus8.issue_hart, m_pipe[0]);
            end
            n_checks++;
            if (bus8.issue_valid === 1'b1 && bus8.issue_hart !== 3'd0 && bus8.issue_hart !== 3'd2) begin
                n_fail++;
                $display("FAIL mask_id c=%0d: got %0d want 0 or 2", c, bus8.issue_hart);
            end
        end
    endtask

    task automatic test_sleep_wake();
        bit seen;
        do_reset();
        for (int j = 0; j < 20 && m_pipe[D-1] != 3; j++) drive(8'hFF, 1'b0, 8'h00);
        n_checks++;
        if (!(bus8.retire_valid === 1'b1 && bus8.retire_hart === 3'd3)) begin
            n_fail++;
            $display("FAIL sleep_retire: got v=%0b h=%0d want hart 3", bus8.retire_valid, bus8.retire_hart);
        end
        drive(8'hFF, 1'b1, 8'h00);
        for (int c = 0; c < 20; c++) begin
            n_checks++;
            if (bus8.issue_valid === 1'b1 && bus8.issue_hart === 3'd3) begin
                n_fail++;
                $display("FAIL sleep_absent c=%0d: got hart 3 want absent", c);
            end
            drive(8'hFF, 1'b0, 8'h00);
        end
        drive(8'hFF, 1'b0, 8'h08);
        seen = 1'b0;
        for (int c = 0; c < N8 && !seen; c++) begin
            if (bus8.issue_valid === 1'b1 && bus8.issue_hart === 3'd3) seen = 1'b1;
            else drive(8'hFF, 1'b0, 8'h00);
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL wake_issue: got no hart 3 want issue within %0d cycles", N8);
        end
        for (int j = 0; j < 20 && m_pipe[D-1] != 3; j++) drive(8'hFF, 1'b0, 8'h00);
        drive(8'hFF, 1'b1, 8'h08);
        seen = 1'b0;
        for (int c = 0; c < 2 * N8 && !seen; c++) begin
            if (bus8.issue_valid === 1'b1 && bus8.issue_hart === 3'd3) seen = 1'b1;
            else drive(8'hFF, 1'b0, 8'h00);
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL sleep_wake_same: got no hart 3 want hart 3 still issuing");
        end
    endtask

    task automatic test_random();
        logic [7:0] mask;
        logic [7:0] wk;
        logic       sreq;
        do_reset();
        mask = 8'hFF;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) == 0) mask = 8'($urandom_range(0, 255));
            sreq = ($urandom_range(0, 3) == 0);
            wk   = ($urandom_range(0, 5) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            drive(mask, sreq, wk);
            for (int k = 0; k < D; k++) begin
                n_checks++;
                if (bus8.stage_valid[k] !== (m_pipe[k] >= 0) ||
                    (m_pipe[k] >= 0 && bus8.stage_hart[k*3 +: 3] !== 3'(m_pipe[k]))) begin
                    n_fail++;
                    $display("FAIL rand_stage%0d c=%0d: got v=%0b h=%0d want %0d", k, c,
                             bus8.stage_valid[k], bus8.stage_hart[k*3 +: 3], m_pipe[k]);
                end
            end
            n_checks++;
            if (bus8.retire_valid !== (m_pipe[D-1] >= 0) || bus8.bubble_cnt !== 32'(m_bub)) begin
                n_fail++;
                $display("FAIL rand_retire_bub c=%0d: got rv=%0b bub=%0d want %0d/%0d", c,
                         bus8.retire_valid, bus8.bubble_cnt, (m_pipe[D-1] >= 0), m_bub);
            end
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        for (int c = 0; c < 10; c++) drive(8'hFF, 1'b0, 8'h00);
        n_checks++;
        if (bus8.stage_valid !== 6'h3F) begin
            n_fail++;
            $display("FAIL midop_full: got %b want 111111", bus8.stage_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus8.issue_valid !== 1'b0 || bus8.stage_valid !== 6'd0 || bus8.stage_hart !== 18'd0 ||
            bus8.retire_valid !== 1'b0 || bus8.retire_hart !== 3'd0 || bus8.bubble_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL midop_clear: sv=%b sh=%h rv=%0b bub=%0d want all 0",
                     bus8.stage_valid, bus8.stage_hart, bus8.retire_valid, bus8.bubble_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        drive(8'hFF, 1'b0, 8'h00);
        n_checks++;
        if (bus8.issue_valid !== 1'b1 || bus8.issue_hart !== 3'd0 || bus8.retire_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_first: got v=%0b h=%0d rv=%0b want v=1 h=0 rv=0",
                     bus8.issue_valid, bus8.issue_hart, bus8.retire_valid);
        end
    endtask

    initial begin
        bus8.run_mask  = 8'hFF;
        bus8.sleep_req = 1'b0;
        bus8.wake      = 8'h00;
        bus4.run_mask  = 4'hF;
        bus4.sleep_req = 1'b0;
        bus4.wake      = 4'h0;
        m_reset();
        test_reset();
        test_rr_n8();
        test_n4_bubbles();
        test_mask_0101();
        test_sleep_wake();
        test_random();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
